// File: rtl/digit_scan_decoder.sv
// digit_scan_decoder: prescaled digit scanner that drives a registered one-hot
// digit-select bus for a multiplexed 7-segment display, with per-digit
// blanking, synchronous restart and freeze.
// Optional build macro: DSD_GHOST_GUARD_EN adds GUARD cycles of anti-ghosting
// dead time (Y forced to 0) at the start of every digit slot.
module digit_scan_decoder #(
    parameter int SEL_W      = 2,
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 4,
    parameter int GUARD      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_DIGITS-1:0] Y,
    output logic                  step,
    output logic                  wrap
);

    localparam int                PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    // Elaboration-time parameter sanity checks
    if (NUM_DIGITS < 2 || NUM_DIGITS > (1 << SEL_W)) begin : g_bad_num_digits
        $error("digit_scan_decoder: NUM_DIGITS must be 2..2**SEL_W");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("digit_scan_decoder: PRESCALE must be >= 1");
    end
`ifdef DSD_GHOST_GUARD_EN
    if (GUARD < 0 || GUARD > PRESCALE - 1) begin : g_bad_guard
        $error("digit_scan_decoder: GUARD must be 0..PRESCALE-1");
    end
`else
    // GUARD has no effect in this build
    if (GUARD < 0) begin : g_guard_unused
    end
`endif

    logic [PW-1:0]         pre;
    logic [PW-1:0]         pre_n;
    logic [SEL_W-1:0]      sel_n;
    logic [NUM_DIGITS-1:0] y_n;
    logic                  step_n;
    logic                  wrap_n;

    // Next-state: prescaler, digit index, pulses and the one-hot select
    always_comb begin
        pre_n  = pre;
        sel_n  = sel;
        step_n = 1'b0;
        wrap_n = 1'b0;
        y_n    = '0;

        if (clr) begin
            pre_n = '0;
            sel_n = '0;
        end else if (en) begin
            if (pre == PRE_LAST) begin
                pre_n  = '0;
                step_n = 1'b1;
                // Any index at or past the last digit (only reachable by
                // upset) returns to 0; wrap only flags the legal transition.
                if (sel >= SEL_LAST) begin
                    sel_n  = '0;
                    wrap_n = (sel == SEL_LAST);
                end else begin
                    sel_n = sel + 1'b1;
                end
            end else begin
                pre_n = pre + 1'b1;
            end
        end

        // Y is decoded from the next index so it changes together with sel;
        // an out-of-range index matches no bit and leaves Y at zero.
        if (en) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                y_n[k] = (sel_n == SEL_W'(k)) && !blank_mask[k];
            end
`ifdef DSD_GHOST_GUARD_EN
            if (int'(pre_n) < GUARD) begin
                y_n = '0;
            end
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            sel  <= '0;
            Y    <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else begin
            pre  <= pre_n;
            sel  <= sel_n;
            Y    <= y_n;
            step <= step_n;
            wrap <= wrap_n;
        end
    end

endmodule

// File: tb/tb_digit_scan_decoder.sv
// Self-checking bench for digit_scan_decoder: two instances (4 digits /
// prescale 4, and 3 digits / prescale 1) share stimulus and are compared
// every cycle against a counter-based reference model.
module tb_digit_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [3:0] blank_mask;

    logic [1:0] a_sel;
    logic [3:0] a_y;
    logic       a_step;
    logic       a_wrap;
    logic [1:0] b_sel;
    logic [2:0] b_y;
    logic       b_step;
    logic       b_wrap;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, index 0 = instance A, 1 = instance B
    int np[2] = '{4, 1};
    int nd[2] = '{4, 3};
    int ng[2] = '{1, 0};
    int mp[2];
    int ms[2];
    int my[2];
    int mst[2];
    int mw[2];

    digit_scan_decoder #(
        .SEL_W(2), .NUM_DIGITS(4), .PRESCALE(4), .GUARD(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .blank_mask(blank_mask),
        .sel(a_sel), .Y(a_y), .step(a_step), .wrap(a_wrap)
    );

    digit_scan_decoder #(
        .SEL_W(2), .NUM_DIGITS(3), .PRESCALE(1), .GUARD(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .blank_mask(blank_mask[2:0]),
        .sel(b_sel), .Y(b_y), .step(b_step), .wrap(b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mp[d] = 0; ms[d] = 0; my[d] = 0; mst[d] = 0; mw[d] = 0;
        end
    endtask

    // What the next rising edge must produce for the given inputs
    task automatic model_edge(input logic e, input logic c, input logic [3:0] m);
        for (int d = 0; d < 2; d++) begin
            mst[d] = 0;
            mw[d]  = 0;
            if (c) begin
                mp[d] = 0;
                ms[d] = 0;
            end else if (e) begin
                if (mp[d] == np[d] - 1) begin
                    mp[d]  = 0;
                    mst[d] = 1;
                    mw[d]  = (ms[d] == nd[d] - 1) ? 1 : 0;
                    ms[d]  = (ms[d] + 1) % nd[d];
                end else begin
                    mp[d] = mp[d] + 1;
                end
            end
            my[d] = (e && !m[ms[d]]) ? (1 << ms[d]) : 0;
`ifdef DSD_GHOST_GUARD_EN
            if (e && mp[d] < ng[d]) my[d] = 0;
`endif
        end
    endtask

    task automatic compare_all();
        check_eq("A.sel",  32'(a_sel),  32'(ms[0]));
        check_eq("A.Y",    32'(a_y),    32'(my[0]));
        check_eq("A.step", 32'(a_step), 32'(mst[0]));
        check_eq("A.wrap", 32'(a_wrap), 32'(mw[0]));
        check_eq("B.sel",  32'(b_sel),  32'(ms[1]));
        check_eq("B.Y",    32'(b_y),    32'(my[1]));
        check_eq("B.step", 32'(b_step), 32'(mst[1]));
        check_eq("B.wrap", 32'(b_wrap), 32'(mw[1]));
    endtask

    // Called at a falling edge: check current outputs, apply inputs for the next edge
    task automatic cyc(input logic e, input logic c, input logic [3:0] m);
        compare_all();
        en = e;
        clr = c;
        blank_mask = m;
        model_edge(e, c, m);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rm;
        int i;

        rst_n = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        blank_mask = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Free-running scan with nothing blanked
        repeat (40) cyc(1'b1, 1'b0, 4'b0000);

        // Digit 2 blanked
        repeat (20) cyc(1'b1, 1'b0, 4'b0100);

        // Freeze mid-slot at sel=1, pre=2
        i = 0;
        while (i < 64 && !(ms[0] == 1 && mp[0] == 2)) begin
            cyc(1'b1, 1'b0, 4'b0000);
            i++;
        end
        check_eq("freeze_sel", 32'(a_sel), 32'd1);
        repeat (10) cyc(1'b0, 1'b0, 4'b0000);
        repeat (6) cyc(1'b1, 1'b0, 4'b0000);

        // Clear at sel=3, unmasked then masked digit 0
        i = 0;
        while (i < 64 && ms[0] != 3) begin
            cyc(1'b1, 1'b0, 4'b0000);
            i++;
        end
        check_eq("clr_sel3", 32'(a_sel), 32'd3);
        cyc(1'b1, 1'b1, 4'b0000);
        repeat (3) cyc(1'b1, 1'b0, 4'b0000);
        i = 0;
        while (i < 64 && ms[0] != 3) begin
            cyc(1'b1, 1'b0, 4'b0000);
            i++;
        end
        cyc(1'b1, 1'b1, 4'b0001);
        repeat (3) cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b1, 4'b0000);
        repeat (2) cyc(1'b1, 1'b0, 4'b0000);

        // Asynchronous reset mid-cycle, held across an edge
        repeat (5) cyc(1'b1, 1'b0, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Randomised traffic
        repeat (1500) begin
            rm = 4'($urandom);
            cyc(($urandom_range(0, 9) != 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) == 0) ? rm : 4'b0000);
        end
        compare_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
